// File: rtl/ae350_reset_sequencer_if.sv
// ae350_reset_sequencer_if
//   Groups the board-side inputs and SoC-side reset outputs of the reset
//   sequencer. CLK and RSTN stay plain ports on the sequencer.
//   slave  : sequencer side (samples inputs, drives resets/status)
//   master : board/SoC side (drives inputs, observes resets/status)
//   PLL_LOCK, DDR3_INIT, KEY_RSTN : asynchronous inputs to the sequencer
//   POR_RSTN, DDR3_RSTN, HW_RSTN  : active-low resets
//   RST_DONE, DDR3_FAIL, STATE    : status / debug
`timescale 1ns/1ps
interface ae350_reset_sequencer_if;
  logic       PLL_LOCK;
  logic       DDR3_INIT;
  logic       KEY_RSTN;
  logic       POR_RSTN;
  logic       DDR3_RSTN;
  logic       HW_RSTN;
  logic       RST_DONE;
  logic       DDR3_FAIL;
  logic [2:0] STATE;

  modport slave (
    input  PLL_LOCK, DDR3_INIT, KEY_RSTN,
    output POR_RSTN, DDR3_RSTN, HW_RSTN, RST_DONE, DDR3_FAIL, STATE
  );

  modport master (
    output PLL_LOCK, DDR3_INIT, KEY_RSTN,
    input  POR_RSTN, DDR3_RSTN, HW_RSTN, RST_DONE, DDR3_FAIL, STATE
  );
endinterface

// File: rtl/ae350_reset_sequencer.sv
// ae350_reset_sequencer
//   Ordered reset release for the AE350 SoC: PLL lock -> POR -> DDR3
//   controller -> calibration -> core/peripheral reset. Lock loss,
//   calibration loss and push-button presses re-enter the sequence.
//   CLK  : sequencer clock
//   RSTN : asynchronous active-low reset, release synchronized to CLK
//   bus  : ae350_reset_sequencer_if.slave (inputs, resets, status)
`timescale 1ns/1ps
module ae350_reset_sequencer #(
  parameter int LOCK_FILTER  = 16,
  parameter int POR_HOLD     = 1024,
  parameter int DDR_RST_HOLD = 256,
  parameter int CAL_TIMEOUT  = 1048576,
  parameter int HW_HOLD      = 64,
  parameter int DEBOUNCE     = 50000,
  parameter int MAX_RETRY    = 3
) (
  input  logic                          CLK,
  input  logic                          RSTN,
  ae350_reset_sequencer_if.slave        bus
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOCK_WAIT = 3'd1;
  localparam logic [2:0] S_POR_HOLD  = 3'd2;
  localparam logic [2:0] S_DDR_RST   = 3'd3;
  localparam logic [2:0] S_DDR_CAL   = 3'd4;
  localparam logic [2:0] S_HW_HOLD   = 3'd5;
  localparam logic [2:0] S_FAIL      = 3'd6;
  localparam logic [2:0] S_RUN       = 3'd7;

  localparam logic [23:0] LOCK_LAST = 24'(LOCK_FILTER - 1);
  localparam logic [23:0] POR_LAST  = 24'(POR_HOLD - 1);
  localparam logic [23:0] DDR_LAST  = 24'(DDR_RST_HOLD - 1);
  localparam logic [23:0] CAL_LAST  = 24'(CAL_TIMEOUT - 1);
  localparam logic [23:0] HW_LAST   = 24'(HW_HOLD - 1);
  localparam logic [23:0] DB_LAST   = 24'(DEBOUNCE - 1);
  localparam logic [1:0]  RETRY_MAX = 2'(MAX_RETRY);

  // Reset bridge: asserts asynchronously, releases after two CLK edges.
  logic [1:0] rst_sync;
  logic       rst_int_n;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) rst_sync <= 2'b00;
    else       rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  // Input synchronizers are free-running so the synced levels are already
  // valid on the first cycle after the internal reset releases.
  logic [1:0] lock_sync, init_sync, key_sync;
  logic       lock_s, init_s, key_s;

  always_ff @(posedge CLK) begin
    lock_sync <= {lock_sync[0], bus.PLL_LOCK};
    init_sync <= {init_sync[0], bus.DDR3_INIT};
    key_sync  <= {key_sync[0],  bus.KEY_RSTN};
  end
  assign lock_s = lock_sync[1];
  assign init_s = init_sync[1];
  assign key_s  = key_sync[1];

  // Debounce: level follows key_s once it has differed for DEBOUNCE cycles;
  // press is a registered one-cycle pulse on the high->low level change.
  logic        key_lvl;
  logic [23:0] db_cnt;
  logic        press;

  always_ff @(posedge CLK or negedge rst_int_n) begin
    if (!rst_int_n) begin
      key_lvl <= 1'b1;
      db_cnt  <= '0;
      press   <= 1'b0;
    end else begin
      press <= 1'b0;
      if (key_s != key_lvl) begin
        if (db_cnt == DB_LAST) begin
          key_lvl <= key_s;
          db_cnt  <= '0;
          press   <= ~key_s;
        end else begin
          db_cnt <= db_cnt + 24'd1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Next-state logic, priority: lock loss > cal loss > button > counter.
  logic [2:0]  state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [1:0]  retry_q, retry_d;
  logic        lock_loss, cal_loss;

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    lock_loss = !lock_s && (state_q != S_IDLE) && (state_q != S_LOCK_WAIT);
    cal_loss  = !init_s && ((state_q == S_HW_HOLD) || (state_q == S_RUN));
    if (lock_loss) begin
      state_d = S_LOCK_WAIT;
    end else if (cal_loss) begin
      state_d = S_DDR_RST;
    end else if (press && (state_q == S_RUN)) begin
      state_d = S_HW_HOLD;
    end else begin
      case (state_q)
        S_IDLE:      state_d = S_LOCK_WAIT;
        S_LOCK_WAIT: if (lock_s && cnt_q == LOCK_LAST) state_d = S_POR_HOLD;
        S_POR_HOLD:  if (cnt_q == POR_LAST) state_d = S_DDR_RST;
        S_DDR_RST:   if (cnt_q == DDR_LAST) state_d = S_DDR_CAL;
        S_DDR_CAL: begin
          if (init_s) begin
            state_d = S_HW_HOLD;
          end else if (cnt_q == CAL_LAST) begin
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + 2'd1;
              state_d = S_DDR_RST;
            end else begin
              state_d = S_FAIL;
            end
          end
        end
        S_HW_HOLD:   if (cnt_q == HW_LAST) state_d = S_RUN;
        default:     state_d = state_q;
      endcase
    end
    if (lock_loss || (state_d == S_RUN && state_q != S_RUN)) retry_d = '0;

    // Shared counter restarts on every state change.
    cnt_d = '0;
    if (state_d == state_q) begin
      case (state_q)
        S_LOCK_WAIT: cnt_d = lock_s ? cnt_q + 24'd1 : '0;
        S_POR_HOLD, S_DDR_RST, S_DDR_CAL, S_HW_HOLD: cnt_d = cnt_q + 24'd1;
        default:     cnt_d = '0;
      endcase
    end
  end

  // Outputs decoded from the next state so they move with STATE.
  logic por_d, ddr_d, hw_d, done_d, fail_d;

  always_comb begin
    por_d  = 1'b0;
    ddr_d  = 1'b0;
    hw_d   = 1'b0;
    done_d = 1'b0;
    fail_d = 1'b0;
    case (state_d)
      S_DDR_RST:              por_d = 1'b1;
      S_DDR_CAL, S_HW_HOLD: begin
        por_d = 1'b1;
        ddr_d = 1'b1;
      end
      S_FAIL: begin
        por_d  = 1'b1;
        fail_d = 1'b1;
      end
      S_RUN: begin
        por_d  = 1'b1;
        ddr_d  = 1'b1;
        hw_d   = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      retry_q       <= '0;
      bus.POR_RSTN  <= 1'b0;
      bus.DDR3_RSTN <= 1'b0;
      bus.HW_RSTN   <= 1'b0;
      bus.RST_DONE  <= 1'b0;
      bus.DDR3_FAIL <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      bus.POR_RSTN  <= por_d;
      bus.DDR3_RSTN <= ddr_d;
      bus.HW_RSTN   <= hw_d;
      bus.RST_DONE  <= done_d;
      bus.DDR3_FAIL <= fail_d;
    end
  end

  assign bus.STATE = state_q;

endmodule

// File: tb/tb_ae350_reset_sequencer.sv
`timescale 1ns/1ps
module tb_ae350_reset_sequencer;
  localparam int LF = 4, PH = 8, DH = 4, CT = 16, HH = 4, DB = 3, MR = 1;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Results of run_seq: first edge (from its start) each output is seen high.
  int   por_e, ddr_e, hw_e, done_e, fail_e;
  bit   por_dropped;
  int   seq_code;   // visited states packed as octal digits
  int   last_state;

  ae350_reset_sequencer_if bus ();

  ae350_reset_sequencer #(
    .LOCK_FILTER(LF), .POR_HOLD(PH), .DDR_RST_HOLD(DH), .CAL_TIMEOUT(CT),
    .HW_HOLD(HH), .DEBOUNCE(DB), .MAX_RETRY(MR)
  ) dut (
    .CLK (clk),
    .RSTN(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves rstn high 1ns after an edge; that edge's successors are R1, R2,...
  // Internal reset releases after R2, so IDLE->LOCK_WAIT happens at R3.
  task automatic release_reset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic run_seq(input int n, input int init_at, input int glitch_at);
    por_e = 0; ddr_e = 0; hw_e = 0; done_e = 0; fail_e = 0;
    por_dropped = 1'b0;
    last_state  = int'(bus.STATE);
    seq_code    = last_state;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (bus.POR_RSTN  === 1'b1 && por_e  == 0) por_e  = k;
      if (bus.DDR3_RSTN === 1'b1 && ddr_e  == 0) ddr_e  = k;
      if (bus.HW_RSTN   === 1'b1 && hw_e   == 0) hw_e   = k;
      if (bus.RST_DONE  === 1'b1 && done_e == 0) done_e = k;
      if (bus.DDR3_FAIL === 1'b1 && fail_e == 0) fail_e = k;
      if (bus.POR_RSTN !== 1'b1) por_dropped = 1'b1;
      if (int'(bus.STATE) != last_state) begin
        last_state = int'(bus.STATE);
        seq_code   = seq_code * 8 + last_state;
      end
      if (k == init_at) bus.DDR3_INIT = 1'b1;
      if (k == glitch_at) bus.PLL_LOCK = 1'b0;
      if (glitch_at > 0 && k == glitch_at + 1) bus.PLL_LOCK = 1'b1;
    end
  endtask

  // DDR3_INIT driven high after R24 (5 cycles after DDR3_RSTN rises at R19).
  task automatic bring_up();
    bus.DDR3_INIT = 1'b0;
    release_reset();
    run_seq(32, 24, 0);
  endtask

  task automatic test_reset();
    n_checks++; if (bus.STATE !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", bus.STATE); end
    n_checks++; if ({bus.POR_RSTN, bus.DDR3_RSTN, bus.HW_RSTN, bus.RST_DONE, bus.DDR3_FAIL} !== 5'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected 00000", {bus.POR_RSTN, bus.DDR3_RSTN, bus.HW_RSTN, bus.RST_DONE, bus.DDR3_FAIL}); end
    release_reset();
    run_seq(10, 0, 0);
    n_checks++; if (seq_code !== 'o012) begin n_fail++; $display("FAIL early_seq: got %o expected 12", seq_code); end
    // Asynchronous assertion mid-sequence, checked before any clock edge.
    rstn = 1'b0;
    #2;
    n_checks++; if (bus.STATE !== 3'd0) begin n_fail++; $display("FAIL async_reset_state: got %0d expected 0", bus.STATE); end
  endtask

  task automatic test_normal();
    bring_up();
    n_checks++; if (seq_code !== 'o123457) begin n_fail++; $display("FAIL normal_seq: got %o expected 123457", seq_code); end
    n_checks++; if (por_e !== 15) begin n_fail++; $display("FAIL normal_por_edge: got %0d expected 15", por_e); end
    n_checks++; if (ddr_e !== 19) begin n_fail++; $display("FAIL normal_ddr_edge: got %0d expected 19", ddr_e); end
    n_checks++; if (hw_e !== 31) begin n_fail++; $display("FAIL normal_hw_edge: got %0d expected 31", hw_e); end
    n_checks++; if (done_e !== 31) begin n_fail++; $display("FAIL normal_done_edge: got %0d expected 31", done_e); end
  endtask

  // Pin low only for the sample taken at R5; the synced low reaches the
  // filter at R7, restarting it: POR rises 4 edges late (glitch 1 + 3).
  task automatic test_lock_glitch();
    bus.DDR3_INIT = 1'b0;
    release_reset();
    run_seq(24, 0, 4);
    n_checks++; if (por_e !== 19) begin n_fail++; $display("FAIL glitch_por_edge: got %0d expected 19", por_e); end
    n_checks++; if (ddr_e !== 23) begin n_fail++; $display("FAIL glitch_ddr_edge: got %0d expected 23", ddr_e); end
  endtask

  task automatic test_cal_timeout();
    bus.DDR3_INIT = 1'b0;
    release_reset();
    run_seq(55, 0, 0);
    n_checks++; if (seq_code !== 'o1234346) begin n_fail++; $display("FAIL timeout_seq: got %o expected 1234346", seq_code); end
    n_checks++; if (fail_e !== 55) begin n_fail++; $display("FAIL timeout_fail_edge: got %0d expected 55", fail_e); end
    repeat (5) tick();
    n_checks++; if ({bus.STATE, bus.POR_RSTN, bus.DDR3_RSTN, bus.HW_RSTN, bus.DDR3_FAIL} !== {3'd6, 4'b1001}) begin
      n_fail++; $display("FAIL fail_outputs: got state %0d por/ddr/hw/fail %b expected 6 1001", bus.STATE, {bus.POR_RSTN, bus.DDR3_RSTN, bus.HW_RSTN, bus.DDR3_FAIL}); end
    rstn = 1'b0;
    #2;
    n_checks++; if ({bus.STATE, bus.DDR3_FAIL, bus.POR_RSTN} !== 5'b0) begin
      n_fail++; $display("FAIL fail_reset: got state %0d fail %b por %b expected 0 0 0", bus.STATE, bus.DDR3_FAIL, bus.POR_RSTN); end
    release_reset();
    run_seq(3, 0, 0);
    n_checks++; if (seq_code !== 'o01) begin n_fail++; $display("FAIL fail_restart_seq: got %o expected 1", seq_code); end
  endtask

  task automatic test_run_disturb();
    bring_up();
    n_checks++; if (bus.STATE !== 3'd7) begin n_fail++; $display("FAIL run_reached: got %0d expected 7", bus.STATE); end
    // Lock loss: reaction on the third edge after the pin falls.
    bus.PLL_LOCK = 1'b0;
    tick(); tick();
    n_checks++; if (bus.STATE !== 3'd7) begin n_fail++; $display("FAIL lockloss_early: got %0d expected 7", bus.STATE); end
    tick();
    n_checks++; if ({bus.STATE, bus.POR_RSTN, bus.DDR3_RSTN, bus.HW_RSTN, bus.RST_DONE} !== {3'd1, 4'b0000}) begin
      n_fail++; $display("FAIL lockloss_outputs: got state %0d resets/done %b expected 1 0000", bus.STATE, {bus.POR_RSTN, bus.DDR3_RSTN, bus.HW_RSTN, bus.RST_DONE}); end
    bus.PLL_LOCK = 1'b1;
    run_seq(24, 0, 0);
    n_checks++; if (seq_code !== 'o123457) begin n_fail++; $display("FAIL relock_seq: got %o expected 123457", seq_code); end
    n_checks++; if (por_e !== 14) begin n_fail++; $display("FAIL relock_por_edge: got %0d expected 14", por_e); end
    n_checks++; if (done_e !== 23) begin n_fail++; $display("FAIL relock_done_edge: got %0d expected 23", done_e); end
    // Calibration loss in RUN.
    bus.DDR3_INIT = 1'b0;
    tick(); tick(); tick();
    n_checks++; if ({bus.STATE, bus.POR_RSTN, bus.DDR3_RSTN, bus.HW_RSTN} !== {3'd3, 3'b100}) begin
      n_fail++; $display("FAIL calloss_outputs: got state %0d por/ddr/hw %b expected 3 100", bus.STATE, {bus.POR_RSTN, bus.DDR3_RSTN, bus.HW_RSTN}); end
    bus.DDR3_INIT = 1'b1;
    run_seq(12, 0, 0);
    n_checks++; if (seq_code !== 'o3457) begin n_fail++; $display("FAIL calloss_seq: got %o expected 3457", seq_code); end
    n_checks++; if (ddr_e !== 4) begin n_fail++; $display("FAIL calloss_ddr_edge: got %0d expected 4", ddr_e); end
    n_checks++; if (done_e !== 9) begin n_fail++; $display("FAIL calloss_done_edge: got %0d expected 9", done_e); end
    n_checks++; if (por_dropped !== 1'b0) begin n_fail++; $display("FAIL calloss_por_held: got dropped=%0d expected 0", por_dropped); end
  endtask

  task automatic test_button();
    int pat[30] = '{0,0,1,1,1, 0,0,1,1,1, 0,0,0,0,0,0,0,0,0,0, 1,1,1,1,1,1,1,1,1,1};
    int entries = 0, hw_low = 0, first_low = 0, prev = 7;
    bit upstream_drop = 1'b0;
    for (int i = 0; i < 30; i++) begin
      bus.KEY_RSTN = pat[i][0];
      tick();
      if (bus.STATE == 3'd5 && prev != 5) entries++;
      prev = int'(bus.STATE);
      if (bus.HW_RSTN !== 1'b1) begin hw_low++; if (first_low == 0) first_low = i + 1; end
      if (bus.POR_RSTN !== 1'b1 || bus.DDR3_RSTN !== 1'b1) upstream_drop = 1'b1;
    end
    n_checks++; if (entries !== 1) begin n_fail++; $display("FAIL button_entries: got %0d expected 1", entries); end
    n_checks++; if (hw_low !== 4) begin n_fail++; $display("FAIL button_hw_low_cycles: got %0d expected 4", hw_low); end
    n_checks++; if (first_low !== 16) begin n_fail++; $display("FAIL button_latency: got %0d expected 16", first_low); end
    n_checks++; if (upstream_drop !== 1'b0) begin n_fail++; $display("FAIL button_upstream: got dropped=%0d expected 0", upstream_drop); end
    // Held press: one event only.
    entries = 0;
    bus.KEY_RSTN = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bus.STATE == 3'd5 && prev != 5) entries++;
      prev = int'(bus.STATE);
    end
    n_checks++; if (entries !== 1) begin n_fail++; $display("FAIL button_held_entries: got %0d expected 1", entries); end
    n_checks++; if (bus.STATE !== 3'd7) begin n_fail++; $display("FAIL button_held_state: got %0d expected 7", bus.STATE); end
    bus.KEY_RSTN = 1'b1;
    repeat (8) tick();
  endtask

  // Press event and lock loss both reach the FSM on edge 6.
  task automatic test_simultaneous();
    bus.KEY_RSTN = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 3) bus.PLL_LOCK = 1'b0;
      if (k == 5) begin
        n_checks++; if (bus.STATE !== 3'd7) begin n_fail++; $display("FAIL simul_before: got %0d expected 7", bus.STATE); end
      end
    end
    n_checks++; if (bus.STATE !== 3'd1) begin n_fail++; $display("FAIL simul_state: got %0d expected 1", bus.STATE); end
    n_checks++; if ({bus.POR_RSTN, bus.HW_RSTN, bus.RST_DONE} !== 3'b000) begin
      n_fail++; $display("FAIL simul_outputs: got %b expected 000", {bus.POR_RSTN, bus.HW_RSTN, bus.RST_DONE}); end
    bus.PLL_LOCK = 1'b1;
    bus.KEY_RSTN = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    bus.PLL_LOCK  = 1'b1;
    bus.DDR3_INIT = 1'b0;
    bus.KEY_RSTN  = 1'b1;
    rstn = 1'b0;
    repeat (3) tick();
    test_reset();
    test_normal();
    test_lock_glitch();
    test_cal_timeout();
    test_run_disturb();
    test_button();
    test_simultaneous();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
